// File: rtl/logic_unit_pipe.sv
// Two-stage pipelined logic unit: eight bitwise/shift functions behind a valid/ready handshake.
// Optional macro LOGIC_PARITY_EN adds a registered even-parity output (out_parity).
module logic_unit_pipe #(
  parameter int WIDTH   = 16,
  parameter int COUNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic [2:0]         in_fun,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH:0]     out_data,
  output logic               out_zero,
  output logic               out_busy,
  output logic [COUNT_W-1:0] op_count
`ifdef LOGIC_PARITY_EN
  ,
  output logic               out_parity
`endif
);

  logic               r_s1_valid;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [2:0]         r_fun;
  logic               r_s2_valid;
  logic [WIDTH:0]     r_data;
  logic               r_zero;
  logic [COUNT_W-1:0] r_count;

  logic               w_s2_free;
  logic               w_s2_load;
  logic               w_accept;
  logic               w_consume;
  logic [WIDTH:0]     w_result;
  logic               w_zero;

  // Handshake: a transfer happens on a rising edge where valid & ready are both 1;
  // valid never depends on ready, and in_ready is the only path fed by out_ready.
  assign w_s2_free = !r_s2_valid || out_ready;
  assign w_s2_load = r_s1_valid && w_s2_free;
  assign in_ready  = !r_s1_valid || w_s2_free;
  assign w_accept  = in_valid && in_ready;
  assign w_consume = r_s2_valid && out_ready;

  always_comb begin
    w_result = '0;
    case (r_fun)
      3'b000:  w_result = {1'b0, r_a & r_b};
      3'b001:  w_result = {1'b0, r_a | r_b};
      3'b010:  w_result = {1'b0, ~(r_a & r_b)};
      3'b011:  w_result = {1'b0, ~(r_a | r_b)};
      3'b100:  w_result = {1'b0, r_a ^ r_b};
      3'b101:  w_result = {1'b0, ~(r_a ^ r_b)};
      3'b110:  w_result = {r_a, 1'b0};
      default: w_result = {r_a[0], 1'b0, r_a[WIDTH-1:1]};
    endcase
  end

  assign w_zero = (w_result[WIDTH-1:0] == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_a        <= '0;
      r_b        <= '0;
      r_fun      <= '0;
    end else begin
      if (w_accept) begin
        r_s1_valid <= 1'b1;
        r_a        <= in_a;
        r_b        <= in_b;
        r_fun      <= in_fun;
      end else if (w_s2_load) begin
        r_s1_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
      r_data     <= '0;
      r_zero     <= 1'b0;
    end else begin
      if (w_s2_load) begin
        r_s2_valid <= 1'b1;
        r_data     <= w_result;
        r_zero     <= w_zero;
      end else if (w_consume) begin
        r_s2_valid <= 1'b0;
      end
    end
  end

  // Saturating count of results taken by the downstream consumer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (w_consume && (r_count != {COUNT_W{1'b1}})) begin
      r_count <= r_count + COUNT_W'(1);
    end
  end

`ifdef LOGIC_PARITY_EN
  logic r_parity;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_parity <= 1'b0;
    end else if (w_s2_load) begin
      r_parity <= ^w_result[WIDTH-1:0];
    end
  end

  assign out_parity = r_parity;
`endif

  assign out_valid = r_s2_valid;
  assign out_data  = r_data;
  assign out_zero  = r_zero;
  assign out_busy  = r_s1_valid || r_s2_valid;
  assign op_count  = r_count;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Bench for logic_unit_pipe: directed steps plus random traffic checked against a queue-based reference model.
module tb_logic_unit_pipe;
  localparam int W    = 16;
  localparam int CW   = 8;
  localparam int MAXC = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_a;
  logic [W-1:0]  in_b;
  logic [2:0]    in_fun;
  logic          out_valid;
  logic          out_ready;
  logic [W:0]    out_data;
  logic          out_zero;
  logic          out_busy;
  logic [CW-1:0] op_count;
`ifdef LOGIC_PARITY_EN
  logic          out_parity;
`endif

  always #5 clk = ~clk;

  logic_unit_pipe #(.WIDTH(W), .COUNT_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_fun    (in_fun),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_zero  (out_zero),
    .out_busy  (out_busy),
    .op_count  (op_count)
`ifdef LOGIC_PARITY_EN
    ,
    .out_parity(out_parity)
`endif
  );

  // Scoreboard: results in acceptance order, plus the cycle each was accepted in.
  logic [W-1:0] exp_q[$];
  logic [W:0]   res_q[$];
  int           acc_q[$];
  int           checks    = 0;
  int           errors    = 0;
  int           cyc       = 0;
  int           exp_count = 0;
  bit           accepted;
  bit           use_ovr   = 0;
  logic [W:0]   ovr;
  bit           prev_stall = 0;
  logic [W:0]   prev_data;

  logic [W:0] sweep_exp [6] = '{17'h0F000, 17'h0FFF0, 17'h00FFF,
                                17'h0000F, 17'h00FF0, 17'h0F00F};

  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic [2:0] f);
    logic [W:0] wa;
    wa = {1'b0, a};
    case (f)
      3'd0:    return {1'b0, a & b};
      3'd1:    return {1'b0, a | b};
      3'd2:    return {1'b0, ~(a & b)};
      3'd3:    return {1'b0, ~(a | b)};
      3'd4:    return {1'b0, a ^ b};
      3'd5:    return {1'b0, ~(a ^ b)};
      3'd6:    return wa * 2;
      default: return (wa / 2) + (a[0] ? (17'd1 << W) : 17'd0);
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One clock: compare outputs at the falling edge, record handshakes, step past the rising edge.
  task automatic cycle();
    logic [W:0] e;
    bit         front_ready;
    @(negedge clk);
    front_ready = (res_q.size() != 0) && (acc_q[0] + 1 < cyc);
    chk("busy",     32'(out_busy),  32'(res_q.size() != 0));
    chk("in_ready", 32'(in_ready),  32'((res_q.size() < 2) || out_ready));
    chk("out_valid", 32'(out_valid), 32'(front_ready));
    chk("op_count", 32'(op_count),  32'(exp_count));
    if (prev_stall) chk("hold_data", 32'(out_data), 32'(prev_data));
    prev_stall = out_valid && !out_ready;
    prev_data  = out_data;
    if (out_valid && out_ready && res_q.size() != 0) begin
      e = res_q.pop_front();
      void'(acc_q.pop_front());
      chk("data", 32'(out_data), 32'(e));
      chk("zero", 32'(out_zero), 32'(e[W-1:0] == 0));
`ifdef LOGIC_PARITY_EN
      chk("parity", 32'(out_parity), 32'(^e[W-1:0]));
`endif
      if (exp_count < MAXC) exp_count++;
    end
    accepted = in_valid && in_ready;
    if (accepted) begin
      res_q.push_back(use_ovr ? ovr : model(in_a, in_b, in_fun));
      acc_q.push_back(cyc);
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] f);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_fun   = f;
    for (int i = 0; i < 50; i++) begin
      cycle();
      if (accepted) break;
    end
    chk("send_accept", 32'(accepted), 32'd1);
    in_valid = 1'b0;
    in_a     = W'($urandom);
    in_b     = W'($urandom);
    in_fun   = 3'($urandom);
  endtask

  task automatic send_dir(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] f,
                          input logic [W:0] expv);
    use_ovr = 1;
    ovr     = expv;
    send(a, b, f);
    use_ovr = 0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    in_valid  = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (res_q.size() == 0) break;
      cycle();
    end
    chk("drain_empty", 32'(res_q.size()), 32'd0);
    cycle();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_out_data"},  32'(out_data),  32'd0);
    chk({tag, "_out_zero"},  32'(out_zero),  32'd0);
    chk({tag, "_out_busy"},  32'(out_busy),  32'd0);
    chk({tag, "_op_count"},  32'(op_count),  32'd0);
    chk({tag, "_in_ready"},  32'(in_ready),  32'd1);
`ifdef LOGIC_PARITY_EN
    chk({tag, "_parity"},    32'(out_parity), 32'd0);
`endif
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; in_fun = '0;
    #2;
    check_reset_outputs("por");
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    cyc = 0;

    // Function sweep of the logic codes
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) send_dir(16'hF0F0, 16'hFF00, 3'(i), sweep_exp[i]);
    drain();

    // Shifts, zero flag, parity pattern
    send_dir(16'h8001, 16'hAAAA, 3'b110, 17'h10002);
    send_dir(16'h8001, 16'h5555, 3'b111, 17'h14000);
    send_dir(16'h1234, 16'h0000, 3'b000, 17'h00000);
    send_dir(16'h0007, 16'hFFFF, 3'b000, 17'h00007);
    drain();

    // Backpressure: two accepts fill the pipe, the third waits
    out_ready = 1'b0;
    send(16'h1111, 16'h2222, 3'd1);
    send(16'h3333, 16'h0F0F, 3'd4);
    in_valid = 1'b1; in_a = 16'hC3C3; in_b = 16'h00FF; in_fun = 3'd2;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("bp_stall", 32'(accepted), 32'd0);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (accepted) break;
    end
    chk("bp_third_accept", 32'(accepted), 32'd1);
    drain();

    // Back-to-back throughput
    out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      in_valid = 1'b1;
      in_a = W'($urandom); in_b = W'($urandom); in_fun = 3'($urandom_range(0, 7));
      cycle();
      chk("b2b_accept", 32'(accepted), 32'd1);
    end
    drain();

    // Random traffic, long enough to saturate the counter
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 9) < 8);
      out_ready = ($urandom_range(0, 3) != 0);
      in_a = W'($urandom); in_b = W'($urandom); in_fun = 3'($urandom_range(0, 7));
      cycle();
    end
    drain();
    chk("count_saturated", 32'(op_count), 32'(MAXC));

    // Asynchronous reset with both stages full
    out_ready = 1'b0;
    send(16'hFFFF, 16'h0001, 3'd0);
    send(16'hABCD, 16'h1234, 3'd5);
    cycle();
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    res_q.delete(); acc_q.delete(); exp_q.delete();
    exp_count = 0; prev_stall = 0;
    out_ready = 1'b1;
    @(posedge clk); cyc++; #1;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) cycle();
    send(16'h00F0, 16'h0FF0, 3'd0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
endmodule
